// File: rtl/lane_vote_monitor.sv
// Majority voter for the replicated lanes of the fan-out stage. It flags lanes
// that stay stuck against the majority and counts the samples that disagree.
module lane_vote_monitor #(
  parameter int LANES        = 8,
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [0:LANES-1]   i_lanes,
  output logic               o_vote,
  output logic               o_vote_vld,
  output logic               o_tie,
  output logic [0:LANES-1]   o_lane_fault,
  output logic               o_any_fault,
  output logic [CNT_W-1:0]   o_mismatch_cnt
);

  localparam int             OW   = $clog2(LANES + 1);
  localparam logic [OW-1:0]  HALF = OW'(LANES / 2);
  localparam logic [3:0]     TH   = 4'(FAULT_THRESH);

  typedef enum logic {WARM, RUN} phase_t;

  logic [OW-1:0]    ones;
  logic             tie;
  logic             vote_new;
  logic             acct;
  logic [0:LANES-1] disagree;
  wire  [0:LANES-1] fault_next;
  wire  [0:LANES-1] lane_fault;

  logic             vote_reg, vld_reg, tie_reg, any_reg;
  logic [CNT_W-1:0] mcnt_reg, mcnt_next;
  phase_t           state_reg, state_next;
  logic             warm;

  always_comb begin
    ones = '0;
    for (int i = 0; i < LANES; i++) ones = ones + OW'(i_lanes[i]);
  end

  // An exact half split is only possible with an even lane count.
  assign tie      = ((LANES % 2) == 0) && (ones == HALF);
  assign vote_new = tie ? vote_reg : (ones > HALF);
  assign disagree = i_lanes ^ {LANES{vote_new}};
  assign acct     = i_en && !i_clr && !tie;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [3:0] run_reg, run_next;
    logic       fault_reg;

    always_comb begin
      run_next = run_reg;
      if (i_clr)
        run_next = '0;
      else if (acct)
        run_next = !disagree[gi] ? 4'd0 :
                   (run_reg == TH) ? run_reg : run_reg + 4'd1;
    end

    assign fault_next[gi] = !i_clr && (fault_reg || (run_next == TH));
    assign lane_fault[gi] = fault_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        run_reg   <= '0;
        fault_reg <= 1'b0;
      end else begin
        run_reg   <= run_next;
        fault_reg <= fault_next[gi];
      end
    end
  end

  // One count per accounted sample, however many lanes disagree.
  always_comb begin
    mcnt_next = mcnt_reg;
    if (i_clr)
      mcnt_next = '0;
    else if (acct && (|disagree) && (mcnt_reg != {CNT_W{1'b1}}))
      mcnt_next = mcnt_reg + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vote_reg <= 1'b0;
      vld_reg  <= 1'b0;
      tie_reg  <= 1'b0;
      any_reg  <= 1'b0;
      mcnt_reg <= '0;
    end else begin
      if (i_en) vote_reg <= vote_new;
      vld_reg  <= i_en;
      tie_reg  <= i_en && tie;
      any_reg  <= |fault_next;
      mcnt_reg <= mcnt_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= WARM;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (i_en && !tie) state_next = RUN;
    else if (i_clr)   state_next = WARM;
  end

  always_comb begin
    warm = (state_reg == WARM);
  end

  // A tie never moves the vote, so a warm tie straight after reset reads 0.
  a_warm_tie_holds: assert property (@(posedge i_clk) disable iff (i_rst)
    (warm && i_en && tie) |=> (o_vote == $past(o_vote)));

  assign o_vote         = vote_reg;
  assign o_vote_vld     = vld_reg;
  assign o_tie          = tie_reg;
  assign o_lane_fault   = lane_fault;
  assign o_any_fault    = any_reg;
  assign o_mismatch_cnt = mcnt_reg;

endmodule
